// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: shared types and the request/RAM bundle for mem_arbiter.
// The optional performance counters (macro MEM_ARBITER_PERF_EN) are plain
// ports on mem_arbiter and are not part of this bundle.

package mem_arbiter_pkg;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Datapath request side
  logic      iREN;
  word_t     iaddr;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      ihit;
  logic      dhit;
  word_t     iload;
  word_t     dload;
  logic      merr;

  // RAM side
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;

  // Arbiter view
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );

  // Datapath + RAM model view
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, dhit, iload, dload, merr, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access.
// Data has fixed priority over fetch; a starvation counter forces a fetch
// through after STARVE_MAX consecutive data grants with fetch pending.
// RAM strobes/address/store data are registered; hit/merr strobes and load
// data are combinational in the completing cycle.
// Optional macro MEM_ARBITER_PERF_EN adds icount/dcount/waitcount outputs.

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic           CLK,
  input  logic           RST,
  mem_arbiter_if.slave   bus
`ifdef MEM_ARBITER_PERF_EN
  ,
  output logic [31:0]    icount,
  output logic [31:0]    dcount,
  output logic [31:0]    waitcount
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  logic [3:0] starve_cnt;
  logic       data_req;
  logic       ram_done;

  assign data_req = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);

  // Grant FSM with registered RAM strobes, address and store data
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      bus.ramREN   <= 1'b0;
      bus.ramWEN   <= 1'b0;
      bus.ramaddr  <= '0;
      bus.ramstore <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (data_req && (starve_cnt < STARVE_LIM)) begin
            state        <= DGRANT;
            bus.ramaddr  <= bus.daddr;
            bus.ramstore <= bus.dstore;
            bus.ramREN   <= bus.dREN;
            bus.ramWEN   <= bus.dWEN;
            // Only data grants that overtake a waiting fetch count as starvation
            if (bus.iREN) begin
              if (starve_cnt != STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (bus.iREN) begin
            state       <= IGRANT;
            bus.ramaddr <= bus.iaddr;
            bus.ramREN  <= 1'b1;
            bus.ramWEN  <= 1'b0;
            starve_cnt  <= '0;
          end else begin
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
            starve_cnt <= '0;
          end
        end

        DGRANT: begin
          if (ram_done) begin
            state      <= IDLE;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
          end
        end

        IGRANT: begin
          // A flushed fetch abandons the access even if the RAM is still busy
          if (ram_done || !bus.iREN) begin
            state      <= IDLE;
            bus.ramREN <= 1'b0;
            bus.ramWEN <= 1'b0;
          end
        end

        default: begin
          state      <= IDLE;
          bus.ramREN <= 1'b0;
          bus.ramWEN <= 1'b0;
        end
      endcase
    end
  end

  // Completion strobes and load data in the cycle the RAM finishes
  always_comb begin
    bus.ihit  = 1'b0;
    bus.dhit  = 1'b0;
    bus.merr  = 1'b0;
    bus.iload = '0;
    bus.dload = '0;
    // An access interrupted by reset is abandoned, so it may not complete now
    if (!RST) begin
      unique case (state)
        DGRANT: begin
          if (bus.ramstate == ACCESS) begin
            bus.dhit  = 1'b1;
            bus.dload = bus.ramload;
          end else if (bus.ramstate == ERROR) begin
            bus.merr = 1'b1;
          end
        end
        IGRANT: begin
          if (bus.iREN) begin
            if (bus.ramstate == ACCESS) begin
              bus.ihit  = 1'b1;
              bus.iload = bus.ramload;
            end else if (bus.ramstate == ERROR) begin
              bus.merr = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_ARBITER_PERF_EN
  // Completed access and wait-state counters, wrapping modulo 2^32
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount    <= '0;
      dcount    <= '0;
      waitcount <= '0;
    end else begin
      if (bus.ihit) icount <= icount + 32'd1;
      if (bus.dhit) dcount <= dcount + 32'd1;
      if ((state != IDLE) && (bus.ramstate == BUSY)) waitcount <= waitcount + 32'd1;
    end
  end
`endif

endmodule
